seq_shifter: RTL and testbench

SEQ_SHIFTER -- requirements
Module: seq_shifter

---
 rtl/seq_shifter.sv | 104 ++++++++++
 tb/tb_seq_shifter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : seq_shifter
//  Brief    : Multi-cycle 16-bit shifter (pass/LSL/LSR/ASR), one bit per clock.
//  Revision : 1.0
// ============================================================================
module seq_shifter (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] in,
    input  logic [1:0]  shift,
    input  logic [3:0]  amount,
    output logic [15:0] sout,
    output logic        busy,
    output logic        done,
    output logic        zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] c_OP_PASS = 2'b00;
    localparam logic [1:0] c_OP_LSL  = 2'b01;
    localparam logic [1:0] c_OP_LSR  = 2'b10;
    localparam logic [1:0] c_OP_ASR  = 2'b11;

    state_t      r_state;
    logic [1:0]  r_op;
    logic [3:0]  r_count;
    logic [15:0] w_step;
    logic [3:0]  w_eff;

    always_comb begin
        w_step = sout;
        case (r_op)
            c_OP_LSL: w_step = {sout[14:0], 1'b0};
            c_OP_LSR: w_step = {1'b0, sout[15:1]};
            c_OP_ASR: w_step = {sout[15], sout[15:1]};
            default:  w_step = sout;
        endcase
    end

    // A pass operation completes immediately regardless of the requested amount.
    assign w_eff = (shift == c_OP_PASS) ? 4'd0 : amount;
    assign zero  = (sout == 16'h0000);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_op    <= c_OP_PASS;
            r_count <= 4'd0;
            sout    <= 16'h0000;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        sout    <= in;
                        r_op    <= shift;
                        r_count <= w_eff;
                        if (w_eff == 4'd0) begin
                            r_state <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            r_state <= SHIFT;
                            busy    <= 1'b1;
                            done    <= 1'b0;
                        end
                    end else begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end
                end
                SHIFT: begin
                    sout <= w_step;
                    if (r_count != 4'd0) begin
                        r_count <= r_count - 4'd1;
                    end
                    // Final step: the count leaves 1 on this edge.
                    if (r_count <= 4'd1) begin
                        r_state <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_shifter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_seq_shifter
//  Brief    : Scoreboard bench for seq_shifter with random and directed ops.
//  Revision : 1.0
// ============================================================================
module tb_seq_shifter;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] in;
    logic [1:0]  shift;
    logic [3:0]  amount;
    logic [15:0] sout;
    logic        busy;
    logic        done;
    logic        zero;

    typedef struct {
        logic [15:0] res;
        int          n;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    seq_shifter dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .in     (in),
        .shift  (shift),
        .amount (amount),
        .sout   (sout),
        .busy   (busy),
        .done   (done),
        .zero   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_model(input logic [15:0] a, input logic [1:0] s,
                                              input logic [3:0] m);
        logic signed [15:0] t;
        t = a;
        case (s)
            2'b00:   return a;
            2'b01:   return a << m;
            2'b10:   return a >> m;
            default: return t >>> m;
        endcase
    endfunction

    // Issue one operation at a negedge; returns at the negedge after the accept edge.
    task automatic do_op(input logic [15:0] a, input logic [1:0] s, input logic [3:0] m);
        exp_t e;
        e.n   = (s == 2'b00) ? 0 : int'(m);
        e.res = ref_model(a, s, m);
        e.cyc = cyc + 1 + e.n;
        sb.push_back(e);
        in     = a;
        shift  = s;
        amount = m;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        in     = 16'($urandom);
        shift  = 2'($urandom);
        amount = 4'($urandom);
    endtask

    task automatic glitch_start();
        start  = 1'b1;
        in     = 16'hFFFF;
        shift  = 2'($urandom);
        amount = 4'($urandom);
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL wait_done timeout actual=0 required=1 t=%0t", $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever done is presented.
    initial begin
        int   busy_cnt = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_cnt = 0;
            end else begin
                chk("zero_flag", int'(zero), int'(sout == 16'h0000));
                chk("busy_done_excl", int'(busy && done), 0);
                if (busy) busy_cnt++;
                if (done) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done actual=1 required=0 t=%0t", $time);
                    end else begin
                        e = sb.pop_front();
                        chk("sout", int'(sout), int'(e.res));
                        chk("zero_at_done", int'(zero), int'(e.res == 16'h0000));
                        chk("done_cycle", cyc, e.cyc);
                        chk("busy_cycles", busy_cnt, e.n);
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        logic [1:0]  s;
        logic [3:0]  m;
        reset = 1'b1; start = 1'b0; in = 16'h0; shift = 2'b00; amount = 4'd0;
        #1;
        chk("rst_sout", int'(sout), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_zero", int'(zero), 1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        do_op(16'h0001, 2'b01, 4'd4);  wait_done(); @(negedge clk);
        do_op(16'h8000, 2'b11, 4'd15); wait_done(); @(negedge clk);
        do_op(16'h8000, 2'b10, 4'd15); wait_done(); @(negedge clk);
        do_op(16'hA5A5, 2'($urandom), 4'd0); wait_done(); @(negedge clk);
        do_op(16'h1234, 2'b00, 4'd7);  wait_done(); @(negedge clk);

        // Start during SHIFT is ignored, then a back-to-back op from DONE.
        do_op(16'h00F0, 2'b10, 4'd3);
        glitch_start();
        wait_done();
        do_op(16'h0003, 2'b01, 4'd1);
        wait_done();
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom);
            s = 2'($urandom);
            m = 4'($urandom);
            do_op(a, s, m);
            if (s != 2'b00 && m != 4'd0 && $urandom_range(0, 1) == 1) glitch_start();
            wait_done();
            if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        @(negedge clk);

        // Asynchronous reset in the middle of a long operation.
        do_op(16'h1234, 2'b01, 4'd8);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_sout", int'(sout), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_zero", int'(zero), 1);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);

        // Start held high on the first edge after reset release.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        do_op(16'h0001, 2'b01, 4'd1);
        wait_done();
        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
